mem_subword_unit: RTL and testbench

- Multi-cycle load/store sequencer between the pipeline MEM stage and a word-only synchronous data RAM.
- Performs byte, halfword and word accesses with sign/zero extension on loads.
- Sub-word stores use read-modify-write, because the RAM has no byte enables.
- Little-endian lane order: addr[1]=1 selects bits 31:16; addr[1:0]=3 selects bits 31:24.

---
 rtl/mem_pkg.sv | 17 +
 rtl/subword_lane.sv | 53 +++++
 rtl/mem_subword_unit.sv | 155 +++++++++++++++
 tb/tb_mem_subword_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the sub-word load/store sequencer.
// Holds the access-size codes and the FSM state type.
package mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } state_e;

endpackage

// File: rtl/subword_lane.sv
// Combinational lane logic: load extraction with sign/zero extension
// and store merge of a byte/half into a read word.
// Ports: word_i (RAM word), size_i, addr_i (low addr bits), sign_i,
//        wdata_i (right-justified store data); ld_o (load value),
//        st_o (merged store word).
module subword_lane
   import mem_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_i,
   input  logic        sign_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_o,
   output logic [31:0] st_o
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      unique case (addr_i)
         2'd0:    b = word_i[7:0];
         2'd1:    b = word_i[15:8];
         2'd2:    b = word_i[23:16];
         default: b = word_i[31:24];
      endcase
      // bit 0 is ignored for halves: aligns down to 2 bytes
      h = addr_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      ld_o = word_i;
      st_o = wdata_i;
      unique case (size_i)
         SZ_BYTE: begin
            ld_o = {{24{sign_i & b[7]}}, b};
            st_o = word_i;
            st_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            ld_o = {{16{sign_i & h[15]}}, h};
            st_o = word_i;
            st_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            ld_o = word_i;
            st_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_subword_unit.sv
// Multi-cycle byte/half/word load-store sequencer in front of a
// word-only synchronous RAM; sub-word stores use read-modify-write.
// Ports: clk, rst_n (sync, active-low); req_* request (valid/ready);
//        resp_* one-cycle completion; mem_* RAM strobes/addr/data.
// Option: define MISALIGN_TRAP_EN to trap misaligned half/word
//         accesses with resp_err instead of aligning them down.
module mem_subword_unit
   import mem_pkg::*;
#(
   parameter int MEM_LAT = 1,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_sign,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

   state_e            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [1:0]        size_q, size_d;
   logic              sign_q, sign_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              err_q, err_d;

   logic [1:0]  req_sz;
   logic        misal;
   logic [31:0] ld_val;
   logic [31:0] st_word;

   // size 11 is folded into word at capture
   assign req_sz = (req_size == 2'b11) ? SZ_WORD : req_size;
   assign misal  = ((req_sz == SZ_HALF) && req_addr[0]) ||
                   ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));

   subword_lane u_lane (
      .word_i  (rdata_q),
      .size_i  (size_q),
      .addr_i  (addr_q[1:0]),
      .sign_i  (sign_q),
      .wdata_i (wdata_q),
      .ld_o    (ld_val),
      .st_o    (st_word)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         size_q  <= size_d;
         sign_q  <= sign_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      size_d  = size_q;
      sign_d  = sign_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_sz;
               sign_d  = req_sign;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               err_d   = 1'b0;
               if (req_we && (req_sz == SZ_WORD)) state_d = WR;
               else                               state_d = RD;
`ifdef MISALIGN_TRAP_EN
               if (misal) begin
                  state_d = RESP;
                  err_d   = 1'b1;
               end
`endif
            end
         end
         RD: begin
            cnt_d   = LAT_M1;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == 3'd0) begin
               rdata_d = mem_rdata;
               state_d = we_q ? WR : RESP;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         WR:      state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_q == IDLE);
      mem_en     = (state_q == RD) || (state_q == WR);
      mem_we     = (state_q == WR);
      mem_addr   = mem_en ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      mem_wdata  = '0;
      if (mem_we)
         mem_wdata = (size_q == SZ_WORD) ? wdata_q : st_word;
      resp_valid = (state_q == RESP);
      resp_rdata = (resp_valid && !we_q && !err_q) ? ld_val : '0;
`ifdef MISALIGN_TRAP_EN
      resp_err   = resp_valid && err_q;
`else
      resp_err   = 1'b0;
`endif
   end

   logic unused_misal;
   assign unused_misal = misal;

endmodule

// File: tb/tb_mem_subword_unit.sv
// Scoreboard bench for mem_subword_unit with behavioural RAMs
// (MEM_LAT=1 main instance, MEM_LAT=3 second instance).
module tb_mem_subword_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        req_valid, req_ready, req_we, req_sign;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   logic        c_valid, c_ready, c_we, c_sign;
   logic [1:0]  c_size;
   logic [31:0] c_addr, c_wdata;
   logic        c_resp_valid, c_resp_err;
   logic [31:0] c_resp_rdata;
   logic        c_mem_en, c_mem_we;
   logic [31:0] c_mem_addr, c_mem_wdata, c_mem_rdata;

   mem_subword_unit #(.MEM_LAT(1), .ADDR_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   mem_subword_unit #(.MEM_LAT(3), .ADDR_W(32)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(c_valid), .req_ready(c_ready),
      .req_we(c_we), .req_size(c_size), .req_sign(c_sign),
      .req_addr(c_addr), .req_wdata(c_wdata),
      .resp_valid(c_resp_valid), .resp_rdata(c_resp_rdata),
      .resp_err(c_resp_err),
      .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
      .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata)
   );

   // behavioural RAMs
   logic        ram_init = 1'b0;
   logic [31:0] ram1 [0:255];
   logic [31:0] ram3 [0:255];
   logic [31:0] pipe1;
   logic [31:0] pipe3 [0:2];
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   int          en_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;

   always @(posedge clk) begin
      if (ram_init) ram1[8'h40] <= 32'h8765_4321;
      if (mem_en && mem_we) begin
         ram1[mem_addr[9:2]] <= mem_wdata;
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= mem_addr;
         wr_data <= mem_wdata;
      end
      if (mem_en && !mem_we) rd_cnt <= rd_cnt + 1;
      if (mem_en) en_cnt <= en_cnt + 1;
      pipe1 <= (mem_en && !mem_we) ? ram1[mem_addr[9:2]]
                                   : 32'hBAD0_BAD0;
   end
   assign mem_rdata = pipe1;

   always @(posedge clk) begin
      if (ram_init) ram3[8'h40] <= 32'h8765_4321;
      if (c_mem_en && c_mem_we) ram3[c_mem_addr[9:2]] <= c_mem_wdata;
      pipe3[0] <= (c_mem_en && !c_mem_we) ? ram3[c_mem_addr[9:2]]
                                          : 32'hBAD0_BAD0;
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign c_mem_rdata = pipe3[2];

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
   } exp_t;
   exp_t sb[$];

   task automatic do_req(input string tag, input logic we,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee,
                         input int el);
      exp_t e;
      bit   seen;
      int   n;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      req_valid = 1'b1;
      req_we    = we;
      req_size  = sz;
      req_sign  = sg;
      req_addr  = a;
      req_wdata = wd;
      e.rdata = er;
      e.err   = ee;
      e.lat   = el;
      sb.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      seen = 1'b0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            seen = 1'b1;
            e = sb.pop_front();
            chk({tag, " rdata"}, resp_rdata, e.rdata);
            chk({tag, " err"}, {31'b0, resp_err}, {31'b0, e.err});
            chk({tag, " lat"}, 32'(c), 32'(e.lat));
         end
      end
      if (!seen) begin
         e = sb.pop_front();
         chk({tag, " timeout"}, 32'd0, 32'd1);
      end
      @(negedge clk);
      chk({tag, " pulse"}, {31'b0, resp_valid}, 32'd0);
      chk({tag, " ready"}, {31'b0, req_ready}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, r0, e0, seen3, lat3, nresp;
      exp_t e;
      rst_n = 1'b0;
      req_valid = 0; req_we = 0; req_size = 0; req_sign = 0;
      req_addr = 0; req_wdata = 0;
      c_valid = 0; c_we = 0; c_size = 0; c_sign = 0;
      c_addr = 0; c_wdata = 0;
      ram_init = 1'b1;
      repeat (2) @(negedge clk);
      ram_init = 1'b0;
      chk("rst ready", {31'b0, req_ready}, 32'd1);
      chk("rst resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst resp_err", {31'b0, resp_err}, 32'd0);
      chk("rst mem_en", {31'b0, mem_en}, 32'd0);
      chk("rst mem_we", {31'b0, mem_we}, 32'd0);
      chk("rst rdata", resp_rdata, 32'd0);
      chk("rst mem_addr", mem_addr, 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_req("lb 103", 0, 2'b00, 1, 32'h103, 0, 32'hFFFF_FF87, 0, 3);
      do_req("lbu 103", 0, 2'b00, 0, 32'h103, 0, 32'h0000_0087, 0, 3);
      do_req("lb 100", 0, 2'b00, 1, 32'h100, 0, 32'h0000_0021, 0, 3);
      do_req("lbu 101", 0, 2'b00, 0, 32'h101, 0, 32'h0000_0043, 0, 3);
      do_req("lh 102", 0, 2'b01, 1, 32'h102, 0, 32'hFFFF_8765, 0, 3);
      do_req("lhu 100", 0, 2'b01, 0, 32'h100, 0, 32'h0000_4321, 0, 3);
      do_req("lh 100", 0, 2'b01, 1, 32'h100, 0, 32'h0000_4321, 0, 3);
      do_req("lw 100", 0, 2'b10, 1, 32'h100, 0, 32'h8765_4321, 0, 3);
      do_req("lsz3 100", 0, 2'b11, 0, 32'h100, 0, 32'h8765_4321, 0, 3);

      w0 = wr_cnt; r0 = rd_cnt;
      do_req("sh 102", 1, 2'b01, 0, 32'h102, 32'h1234_ABCD,
             32'd0, 0, 4);
      chk("sh wr count", 32'(wr_cnt - w0), 32'd1);
      chk("sh rd count", 32'(rd_cnt - r0), 32'd1);
      chk("sh wr addr", wr_addr, 32'h100);
      chk("sh wr data", wr_data, 32'hABCD_4321);
      chk("sh ram", ram1[8'h40], 32'hABCD_4321);

      w0 = wr_cnt; r0 = rd_cnt;
      do_req("sw 100", 1, 2'b10, 0, 32'h100, 32'hDEAD_BEEF,
             32'd0, 0, 2);
      chk("sw rd count", 32'(rd_cnt - r0), 32'd0);
      chk("sw wr count", 32'(wr_cnt - w0), 32'd1);
      chk("sw ram", ram1[8'h40], 32'hDEAD_BEEF);

      do_req("sb 101", 1, 2'b00, 0, 32'h101, 32'h0000_0055,
             32'd0, 0, 4);
      chk("sb ram", ram1[8'h40], 32'hDEAD_55EF);

      ram_init = 1'b1;
      @(negedge clk);
      ram_init = 1'b0;
      chk("reinit ram", ram1[8'h40], 32'h8765_4321);

      e0 = en_cnt;
`ifdef MISALIGN_TRAP_EN
      do_req("lhu 101", 0, 2'b01, 0, 32'h101, 0, 32'd0, 1, 1);
      chk("mis en count", 32'(en_cnt - e0), 32'd0);
`else
      do_req("lhu 101", 0, 2'b01, 0, 32'h101, 0, 32'h0000_4321, 0, 3);
      chk("mis en count", 32'(en_cnt - e0), 32'd1);
`endif

      // MEM_LAT=3 instance
      c_valid = 1'b1; c_we = 1'b0; c_size = 2'b10; c_sign = 1'b0;
      c_addr = 32'h100; c_wdata = 32'd0;
      e.rdata = 32'h8765_4321; e.err = 1'b0; e.lat = 5;
      sb.push_back(e);
      @(posedge clk);
      #1;
      c_valid = 1'b0;
      seen3 = 0; lat3 = 0;
      for (int c = 1; c <= 20 && seen3 == 0; c++) begin
         @(negedge clk);
         if (c_resp_valid) begin
            seen3 = 1;
            lat3 = c;
            e = sb.pop_front();
            chk("lat3 rdata", c_resp_rdata, e.rdata);
            chk("lat3 err", {31'b0, c_resp_err}, {31'b0, e.err});
            chk("lat3 lat", 32'(lat3), 32'(e.lat));
         end
      end
      if (seen3 == 0) begin
         e = sb.pop_front();
         chk("lat3 timeout", 32'd0, 32'd1);
      end
      @(negedge clk);

      // reset during WAIT of a halfword store
      w0 = wr_cnt;
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01;
      req_sign = 1'b0; req_addr = 32'h102; req_wdata = 32'h0000_FFFF;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid rst ready", {31'b0, req_ready}, 32'd1);
      chk("mid rst out", {resp_rdata[29:0], resp_valid, resp_err}
          | mem_addr | mem_wdata | {30'b0, mem_en, mem_we}, 32'd0);
      rst_n = 1'b1;
      nresp = 0;
      repeat (6) begin
         @(negedge clk);
         if (resp_valid) nresp++;
      end
      chk("mid rst no resp", 32'(nresp), 32'd0);
      chk("mid rst no wr", 32'(wr_cnt - w0), 32'd0);
      chk("mid rst ram", ram1[8'h40], 32'h8765_4321);

      do_req("lw after rst", 0, 2'b10, 0, 32'h100, 0,
             32'h8765_4321, 0, 3);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_err);
      $finish;
   end

endmodule
